// File: rtl/dsp_pipe_reg_if.sv
// dsp_pipe_reg_if: bundle for one DSP pipeline register path.
//
// Signals:
//   CE, SCLR              chain clock enable / synchronous clear (from master)
//   in, in_valid          operand word and its qualifier (from master)
//   out, out_valid        last-stage word and its qualifier (from slave)
//   occupancy             count of stages holding a valid word (from slave)
//
// Handshake: in_valid qualifies in on every edge where CE=1. There is no
// ready signal; the producer stalls the path only by dropping CE.
// out_valid qualifies out in the same way.
interface dsp_pipe_reg_if #(
  parameter int WIDTH = 18,
  parameter int CW    = 1
);
  logic             CE;
  logic             SCLR;
  logic [WIDTH-1:0] in;
  logic             in_valid;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic [CW-1:0]    occupancy;

  modport master (
    output CE, SCLR, in, in_valid,
    input  out, out_valid, occupancy
  );

  modport slave (
    input  CE, SCLR, in, in_valid,
    output out, out_valid, occupancy
  );
endinterface

// File: rtl/dsp_pipe_reg.sv
// dsp_pipe_reg: configurable-depth register chain for one DSP operand or
// result path, with a valid bit per stage and a registered occupancy count.
//
// Ports:
//   CLK   rising-edge clock
//   RST   asynchronous active-low reset
//   bus   dsp_pipe_reg_if.slave (CE, SCLR, in, in_valid -> out, out_valid,
//         occupancy)
//
// DEPTH=0 is a pure wire-through; no flops are built and CE/SCLR/CLK are
// ignored. For DEPTH>=1, SCLR beats CE; with CE low the chain either holds
// (CE_CLEAR=0) or clears like SCLR (CE_CLEAR=1).
module dsp_pipe_reg #(
  parameter int          WIDTH     = 18,
  parameter int          DEPTH     = 1,
  parameter int          CE_CLEAR  = 0,
  parameter logic [47:0] RESET_VAL = '0
) (
  input logic         CLK,
  input logic         RST,
  dsp_pipe_reg_if.slave bus
);

  localparam int CW = ($clog2(DEPTH + 1) < 1) ? 1 : $clog2(DEPTH + 1);

  generate
    if (DEPTH == 0) begin : g_bypass
      assign bus.out       = bus.in;
      assign bus.out_valid = bus.in_valid;
      assign bus.occupancy = '0;

      // Controls have no meaning without stages.
      logic unused_ctrl;
      assign unused_ctrl = ^{bus.CE, bus.SCLR, CLK, RST};
    end else begin : g_pipe
      localparam logic [WIDTH-1:0] RV = RESET_VAL[WIDTH-1:0];

      logic [WIDTH-1:0] data_q [DEPTH];
      logic [WIDTH-1:0] data_d [DEPTH];
      logic [DEPTH-1:0] valid_q, valid_d;
      logic [CW-1:0]    occ_q, occ_d;
      logic             clear_all;

      always_comb begin
        clear_all = bus.SCLR || (!bus.CE && (CE_CLEAR != 0));
        data_d    = data_q;
        valid_d   = valid_q;
        occ_d     = occ_q;
        if (clear_all) begin
          for (int k = 0; k < DEPTH; k++) data_d[k] = RV;
          valid_d = '0;
          occ_d   = '0;
        end else if (bus.CE) begin
          // Data shifts regardless of in_valid; validity travels alongside.
          data_d[0]  = bus.in;
          valid_d[0] = bus.in_valid;
          for (int k = 1; k < DEPTH; k++) begin
            data_d[k]  = data_q[k-1];
            valid_d[k] = valid_q[k-1];
          end
          // One word enters, the pre-edge last stage leaves.
          occ_d = occ_q + CW'(bus.in_valid) - CW'(valid_q[DEPTH-1]);
        end
      end

      always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
          for (int k = 0; k < DEPTH; k++) data_q[k] <= RV;
          valid_q <= '0;
          occ_q   <= '0;
        end else begin
          for (int k = 0; k < DEPTH; k++) data_q[k] <= data_d[k];
          valid_q <= valid_d;
          occ_q   <= occ_d;
        end
      end

      assign bus.out       = data_q[DEPTH-1];
      assign bus.out_valid = valid_q[DEPTH-1];
      assign bus.occupancy = occ_q;

      // The counter is a shadow of the valid bits and must never drift.
      a_occ_popcount : assert property (@(posedge CLK) disable iff (!RST)
        occ_q == CW'($countones(valid_q)));
      a_occ_bound : assert property (@(posedge CLK) disable iff (!RST)
        32'(occ_q) <= DEPTH);
    end
  endgenerate

endmodule

// File: tb/tb_dsp_pipe_reg.sv
// Directed bench for dsp_pipe_reg across five configurations sharing one
// clock and reset: DEPTH=3, DEPTH=2 hold, DEPTH=2 legacy clear, DEPTH=4,
// and DEPTH=0 bypass.
module tb_dsp_pipe_reg;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- interfaces and DUTs ----------------
  dsp_pipe_reg_if #(.WIDTH(18), .CW(2)) if_d3  ();
  dsp_pipe_reg_if #(.WIDTH(18), .CW(2)) if_d2h ();
  dsp_pipe_reg_if #(.WIDTH(18), .CW(2)) if_d2c ();
  dsp_pipe_reg_if #(.WIDTH(18), .CW(3)) if_d4  ();
  dsp_pipe_reg_if #(.WIDTH(18), .CW(1)) if_d0  ();

  dsp_pipe_reg #(.WIDTH(18), .DEPTH(3), .CE_CLEAR(0), .RESET_VAL(48'h0))
    u_d3 (.CLK(clk), .RST(rst_n), .bus(if_d3));
  dsp_pipe_reg #(.WIDTH(18), .DEPTH(2), .CE_CLEAR(0), .RESET_VAL(48'h0))
    u_d2h (.CLK(clk), .RST(rst_n), .bus(if_d2h));
  dsp_pipe_reg #(.WIDTH(18), .DEPTH(2), .CE_CLEAR(1), .RESET_VAL(48'h3FFFF))
    u_d2c (.CLK(clk), .RST(rst_n), .bus(if_d2c));
  dsp_pipe_reg #(.WIDTH(18), .DEPTH(4), .CE_CLEAR(0), .RESET_VAL(48'h0))
    u_d4 (.CLK(clk), .RST(rst_n), .bus(if_d4));
  dsp_pipe_reg #(.WIDTH(18), .DEPTH(0), .CE_CLEAR(0), .RESET_VAL(48'h0))
    u_d0 (.CLK(clk), .RST(rst_n), .bus(if_d0));

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [47:0] got,
                       input logic [47:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one edge; inputs were applied beforehand, outputs settle by +1.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bubble pattern expectations for DEPTH=3 (in_valid 1,0,1,0,0,0).
  logic       bub_v   [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  logic       bub_ov  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [1:0] bub_occ [6] = '{2'd1, 2'd1, 2'd2, 2'd1, 2'd1, 2'd0};
  logic [17:0] bub_out [6] = '{18'h0, 18'h0, 18'h101, 18'h102, 18'h103, 18'h104};

  // Bypass vectors.
  logic [17:0] byp_in [4] = '{18'h00000, 18'h3FFFF, 18'h2A5A5, 18'h00001};
  logic        byp_v  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    // Watchdog: the whole run is a fixed sequence of edges.
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    if_d3.CE = 0;  if_d3.SCLR = 0;  if_d3.in = '0;  if_d3.in_valid = 0;
    if_d2h.CE = 0; if_d2h.SCLR = 0; if_d2h.in = '0; if_d2h.in_valid = 0;
    if_d2c.CE = 0; if_d2c.SCLR = 0; if_d2c.in = '0; if_d2c.in_valid = 0;
    if_d4.CE = 0;  if_d4.SCLR = 0;  if_d4.in = '0;  if_d4.in_valid = 0;
    if_d0.CE = 0;  if_d0.SCLR = 0;  if_d0.in = '0;  if_d0.in_valid = 0;

    // ---------- reset state ----------
    tick(); tick();
    check("rst_d3_out",  if_d3.out, 18'h0);
    check("rst_d3_ov",   if_d3.out_valid, 1'b0);
    check("rst_d3_occ",  if_d3.occupancy, 2'd0);
    check("rst_d2c_out", if_d2c.out, 18'h3FFFF);
    rst_n = 1'b1;

    // ---------- latency DEPTH=3 ----------
    if_d3.CE = 1; if_d3.in_valid = 1;
    if_d3.in = 18'h00011; tick();
    check("lat_occ1", if_d3.occupancy, 2'd1);
    check("lat_ov1",  if_d3.out_valid, 1'b0);
    if_d3.in = 18'h00022; tick();
    check("lat_occ2", if_d3.occupancy, 2'd2);
    check("lat_ov2",  if_d3.out_valid, 1'b0);
    if_d3.in = 18'h00033; tick();
    check("lat_occ3", if_d3.occupancy, 2'd3);
    check("lat_out3", if_d3.out, 18'h00011);
    check("lat_ov3",  if_d3.out_valid, 1'b1);
    if_d3.in = 18'h00044; tick();
    check("lat_out4", if_d3.out, 18'h00022);
    check("lat_occ4", if_d3.occupancy, 2'd3);
    if_d3.in = 18'h00055; tick();
    check("lat_out5", if_d3.out, 18'h00033);
    check("lat_occ5", if_d3.occupancy, 2'd3);

    // ---------- async reset mid-cycle while full ----------
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_out", if_d3.out, 18'h0);
    check("arst_ov",  if_d3.out_valid, 1'b0);
    check("arst_occ", if_d3.occupancy, 2'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // ---------- bubbles DEPTH=3 ----------
    for (int i = 0; i < 6; i++) begin
      if_d3.in       = 18'h101 + 18'(i);
      if_d3.in_valid = bub_v[i];
      tick();
      check($sformatf("bub_ov%0d", i),  if_d3.out_valid, bub_ov[i]);
      check($sformatf("bub_occ%0d", i), if_d3.occupancy, bub_occ[i]);
      if (i >= 2) check($sformatf("bub_out%0d", i), if_d3.out, bub_out[i]);
    end
    if_d3.CE = 0; if_d3.in_valid = 0;

    // ---------- hold stall DEPTH=2 ----------
    if_d2h.CE = 1; if_d2h.in_valid = 1;
    if_d2h.in = 18'h0AAAA; tick();
    if_d2h.in = 18'h05555; tick();
    check("hold_fill_out", if_d2h.out, 18'h0AAAA);
    check("hold_fill_occ", if_d2h.occupancy, 2'd2);
    if_d2h.CE = 0; if_d2h.in = 18'h12345;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("hold_out%0d", i), if_d2h.out, 18'h0AAAA);
      check($sformatf("hold_ov%0d", i),  if_d2h.out_valid, 1'b1);
      check($sformatf("hold_occ%0d", i), if_d2h.occupancy, 2'd2);
    end
    if_d2h.CE = 1; if_d2h.in_valid = 0; if_d2h.in = 18'h0;
    tick();
    check("hold_rel_out", if_d2h.out, 18'h05555);
    check("hold_rel_ov",  if_d2h.out_valid, 1'b1);
    check("hold_rel_occ", if_d2h.occupancy, 2'd1);
    tick();
    check("hold_drain_ov",  if_d2h.out_valid, 1'b0);
    check("hold_drain_occ", if_d2h.occupancy, 2'd0);
    if_d2h.CE = 0;

    // ---------- legacy clear DEPTH=2 ----------
    if_d2c.CE = 1; if_d2c.in_valid = 1;
    if_d2c.in = 18'h00001; tick();
    if_d2c.in = 18'h00002; tick();
    check("lclr_fill_out", if_d2c.out, 18'h00001);
    check("lclr_fill_occ", if_d2c.occupancy, 2'd2);
    if_d2c.CE = 0;
    tick();
    check("lclr_out", if_d2c.out, 18'h3FFFF);
    check("lclr_ov",  if_d2c.out_valid, 1'b0);
    check("lclr_occ", if_d2c.occupancy, 2'd0);
    if_d2c.in_valid = 0;

    // ---------- SCLR beats CE, DEPTH=4 ----------
    if_d4.CE = 1; if_d4.in_valid = 1;
    if_d4.in = 18'h00011; tick();
    if_d4.in = 18'h00022; tick();
    if_d4.in = 18'h00033; tick();
    check("sclr_fill_occ", if_d4.occupancy, 3'd3);
    if_d4.SCLR = 1; if_d4.in = 18'h00099;
    tick();
    check("sclr_occ", if_d4.occupancy, 3'd0);
    check("sclr_out", if_d4.out, 18'h0);
    check("sclr_ov",  if_d4.out_valid, 1'b0);
    if_d4.SCLR = 0; if_d4.in_valid = 0; if_d4.in = 18'h0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("sclr_flush_ov%0d", i),  if_d4.out_valid, 1'b0);
      check($sformatf("sclr_flush_out%0d", i), if_d4.out, 18'h0);
      check($sformatf("sclr_flush_occ%0d", i), if_d4.occupancy, 3'd0);
    end
    if_d4.CE = 0;

    // ---------- bypass DEPTH=0 ----------
    for (int i = 0; i < 4; i++) begin
      if_d0.in = byp_in[i]; if_d0.in_valid = byp_v[i];
      if_d0.CE = 1'(i); if_d0.SCLR = 1'(i >> 1);
      #1;
      check($sformatf("byp_out%0d", i), if_d0.out, byp_in[i]);
      check($sformatf("byp_ov%0d", i),  if_d0.out_valid, byp_v[i]);
      check($sformatf("byp_occ%0d", i), if_d0.occupancy, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
